// File: rtl/iob_rom_dp_arb.sv
// Round-robin arbiter sharing one dual-port ROM among N_REQ read requesters.
// Up to two grants per cycle (port A, then port B), read data routed back one cycle later.
module iob_rom_dp_arb #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 11
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  input  logic [N_REQ*ADDR_W-1:0]  req_addr,
  output logic [N_REQ-1:0]         gnt,
  output logic [N_REQ-1:0]         rvalid,
  output logic [N_REQ*DATA_W-1:0]  rdata,
  output logic [ADDR_W-1:0]        rom_addr_a,
  output logic                     rom_r_en_a,
  input  logic [DATA_W-1:0]        rom_r_data_a,
  output logic [ADDR_W-1:0]        rom_addr_b,
  output logic                     rom_r_en_b,
  input  logic [DATA_W-1:0]        rom_r_data_b
);

  localparam int PW = $clog2(N_REQ);
  localparam logic [PW:0]   NQ    = (PW+1)'(N_REQ);
  localparam logic [PW-1:0] LASTQ = PW'(N_REQ - 1);

  // Handshake: requester i holds req[i]/addr until a cycle where req[i] & gnt[i];
  // that cycle is the transfer. Responses have no ready: rvalid[i] lasts exactly one cycle.

  logic [PW-1:0]     ptr, sel_a, sel_b;
  logic              vld_a, vld_b;
  logic [PW-1:0]     win_a, win_b, last, ptr_nxt, idx;
  logic              fnd_a, fnd_b;
  logic [PW:0]       sum;
  logic [ADDR_W-1:0] addr_arr [N_REQ];

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // Walk ptr, ptr+1, ... with wrap; first hit takes port A, second takes port B.
  always_comb begin
    fnd_a = 1'b0;
    fnd_b = 1'b0;
    win_a = '0;
    win_b = '0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = {1'b0, ptr} + (PW+1)'(k);
      if (sum >= NQ) sum = sum - NQ;
      idx = sum[PW-1:0];
      if (req[idx]) begin
        if (!fnd_a) begin
          fnd_a = 1'b1;
          win_a = idx;
        end else if (!fnd_b) begin
          fnd_b = 1'b1;
          win_b = idx;
        end
      end
    end
  end

  always_comb begin
    gnt = '0;
    if (fnd_a) gnt[win_a] = 1'b1;
    if (fnd_b) gnt[win_b] = 1'b1;
  end

  assign rom_r_en_a = fnd_a;
  assign rom_r_en_b = fnd_b;
  assign rom_addr_a = fnd_a ? addr_arr[win_a] : '0;
  assign rom_addr_b = fnd_b ? addr_arr[win_b] : '0;

  assign last    = fnd_b ? win_b : win_a;
  assign ptr_nxt = (last == LASTQ) ? '0 : last + PW'(1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr   <= '0;
      vld_a <= 1'b0;
      vld_b <= 1'b0;
      sel_a <= '0;
      sel_b <= '0;
    end else begin
      if (fnd_a) ptr <= ptr_nxt;
      vld_a <= fnd_a;
      vld_b <= fnd_b;
      sel_a <= win_a;
      sel_b <= win_b;
    end
  end

  // Port A has priority on the (impossible) case of both ports naming the same owner.
  always_comb begin
    rvalid = '0;
    rdata  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (vld_a && (sel_a == PW'(i))) begin
        rvalid[i]                  = 1'b1;
        rdata[i*DATA_W +: DATA_W]  = rom_r_data_a;
      end else if (vld_b && (sel_b == PW'(i))) begin
        rvalid[i]                  = 1'b1;
        rdata[i*DATA_W +: DATA_W]  = rom_r_data_b;
      end
    end
  end

endmodule

// File: doc/iob_rom_dp_arb.md
# iob_rom_dp_arb

Round-robin arbiter that shares one dual-port ROM (two independent registered read ports A and B, 1-cycle read latency, read enable per port) among N_REQ read requesters. Each cycle it grants up to two requesters, one per ROM port, drives the ROM address/enable lines, and routes the returned data back to the granted requesters one cycle later. It sits between the ROM instance and the CPU/DMA-side read clients in the memory subsystem.

## Interface
- N_REQ, 4: number of requesters, 2..16.
- DATA_W, 32: ROM data width.
- ADDR_W, 11: ROM address width.
- clk  in  1  clock; everything samples on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req  in  N_REQ  per-requester read request; bit i = requester i.
- req_addr  in  N_REQ*ADDR_W  packed addresses; slice i is [i*ADDR_W +: ADDR_W].
- gnt  out  N_REQ  combinational grant; request i is accepted in a cycle where req[i] & gnt[i].
- rvalid  out  N_REQ  registered; rvalid[i]=1 exactly one cycle after requester i was granted.
- rdata  out  N_REQ*DATA_W  packed read data; slice i is valid only while rvalid[i]=1.
- rom_addr_a  out  ADDR_W  ROM port A address.
- rom_r_en_a  out  1  ROM port A read enable.
- rom_r_data_a  in  DATA_W  ROM port A data, valid the cycle after rom_r_en_a.
- rom_addr_b, rom_r_en_b, rom_r_data_b: same as port A, for port B.

## Operation
- State: ptr (round-robin pointer, 0..N_REQ-1); sel_a, sel_b (requester index owning each in-flight read); vld_a, vld_b (read in flight on each port).
- Search order each cycle: ptr, ptr+1, …, N_REQ-1, 0, …, ptr-1.
- First requester in search order with req=1 gets port A; second gets port B. At most two grants per cycle; gnt is one-hot or two-hot or zero.
- Port A: rom_r_en_a=1 and rom_addr_a = req_addr slice of its winner; no winner -> rom_r_en_a=0, rom_addr_a=0. Port B likewise.
- gnt depends only on req and ptr (not req_addr) and is never asserted for a requester with req=0.
- Pointer update: if any grant, ptr <= (index of last granted requester + 1) mod N_REQ, where last = port B winner if present, else port A winner. No grant -> ptr holds.
- Pipeline register: vld_a <= rom_r_en_a, sel_a <= port A winner; same for B.
- rvalid[i] = (vld_a & sel_a==i) | (vld_b & sel_b==i); registered state only, no combinational path from req.
- rdata slice i = rom_r_data_a if (vld_a & sel_a==i), else rom_r_data_b if (vld_b & sel_b==i), else 0.
- One requester never wins both ports in the same cycle; a requester granted in cycle t may request again and be granted in t+1 (back-to-back, 1 read/cycle per requester).
- Requesters hold req and req_addr stable until granted; the arbiter does not buffer ungranted requests.
- No backpressure on responses: data is presented for exactly one cycle.

## Timing
- Reset (async assert, sync release on clk): ptr=0, vld_a=vld_b=0, sel_a=sel_b=0 -> rvalid=0, rdata=0 for all slices. gnt, rom_r_en_a/b, rom_addr_a/b follow the combinational rules (0 while req=0).
- Reset mid-operation: in-flight reads are dropped, no rvalid is produced for them, ptr restarts at 0.
- Latency: grant in cycle t -> rvalid and rdata in cycle t+1.
- Throughput: 2 reads/cycle sustained when ≥2 requesters are active.
- Fairness: with all N_REQ requesting continuously, every requester is granted at least once in every ceil(N_REQ/2) consecutive cycles.
- Wrap-around: ptr=N_REQ-1 searches N_REQ-1 then 0, 1, …; last grant at N_REQ-1 sets ptr=0.

## Test plan
- ROM preloaded with rom[k]=0xA0000000+k. Reset, then req=4'b0001, addr0=5 -> cycle t: gnt=0001, rom_r_en_a=1, rom_addr_a=5, rom_r_en_b=0; t+1: rvalid=0001, rdata0=0xA0000005; ptr=1.
- All four requesting continuously, addrs 10,11,12,13, ptr=0 -> grants 0011, 1100, 0011, …; each rvalid carries 0xA000000A+i one cycle after its grant.
- ptr=3, req=1001 -> port A=3, port B=0, gnt=1001, ptr becomes 1; rvalid=1001 next cycle with correct data per slice.
- Requester 2 alone, back-to-back addrs 1,2,3 over 3 cycles -> gnt[2]=1 each cycle, port B idle, rvalid[2] on 3 consecutive cycles with data 0xA0000001..3.
- Assert rst in the cycle after granting requesters 0 and 1 -> rvalid stays 0000, rdata=0, ptr=0 after release.
- req=0 for 10 cycles -> gnt=0, rom_r_en_a=rom_r_en_b=0, rvalid=0, ptr unchanged.
